// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - VRAM write engine: request FIFO plus linear block fill into the SRAM CPU write port
//
// Ports:
//   clk, rst                  controller clock, asynchronous active-high reset
//   req_valid/req_ready       single-pixel write request handshake
//   req_addr, req_data        request word address and pixel data
//   fill_start                one-cycle pulse that latches a block fill
//   fill_base/count/color     first address, word count and data of the fill
//   fill_busy, fill_done      fill latched/in progress, one-cycle completion pulse
//   mem_addr/mem_din/mem_we   registered SRAM controller write port
//   mem_ready                 controller ready; a write completes on mem_we && mem_ready
//   busy                      any work queued or in flight
module vram_writer #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_count,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_next;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [ADDR_W-1:0] fill_addr;
  logic [ADDR_W-1:0] fill_left;
  logic [DATA_W-1:0] fill_data;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full && !fill_busy;
  assign push      = req_valid && req_ready;
  // The head entry stays in the FIFO while it is on the bus; it is popped on completion.
  assign pop       = (state == S_WR) && mem_we && mem_ready;
  assign rd_next   = rd_ptr + 1'b1;
  assign busy      = !empty || fill_busy || mem_we;

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= req_addr;
      q_data[wr_ptr] <= req_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      fill_addr <= '0;
      fill_left <= '0;
      fill_data <= '0;
    end else begin
      fill_done <= 1'b0;

      // A fill is only latched while none is pending, so this never races the clear below.
      if (fill_start && !fill_busy) begin
        fill_busy <= 1'b1;
        fill_addr <= fill_base;
        fill_left <= fill_count;
        fill_data <= fill_color;
      end

      case (state)
        S_IDLE: begin
          if (!empty) begin
            state    <= S_WR;
            mem_we   <= 1'b1;
            mem_addr <= q_addr[rd_ptr];
            mem_din  <= q_data[rd_ptr];
          end else if (fill_busy) begin
            // A zero-length fill enters FILL with mem_we low and completes on the next edge.
            state    <= S_FILL;
            mem_we   <= (fill_left != '0);
            mem_addr <= fill_addr;
            mem_din  <= fill_data;
          end
        end

        S_WR: begin
          if (mem_ready) begin
            if (count > CW'(1)) begin
              mem_addr <= q_addr[rd_next];
              mem_din  <= q_data[rd_next];
            end else if (push) begin
              // The only remaining entry is the one being pushed on this edge.
              mem_addr <= req_addr;
              mem_din  <= req_data;
            end else begin
              mem_we <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end

        S_FILL: begin
          if (!mem_we) begin
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
            state     <= S_IDLE;
          end else if (mem_ready) begin
            if (fill_left == ADDR_W'(1)) begin
              mem_we    <= 1'b0;
              fill_busy <= 1'b0;
              fill_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              mem_addr  <= mem_addr + 1'b1;  // wraps modulo 2^ADDR_W
              fill_left <= fill_left - 1'b1;
            end
          end
        end

        default: begin
          state  <= S_IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vram_writer.md
Name: vram_writer

Overview:
- Write-side engine for the VRAM region of the board SRAM; it is the counterpart of the VGA scan-out read path.
- Accepts single-pixel write requests through a small FIFO, plus a rectangular-free linear block-fill command.
- Drives the SRAM controller's CPU-side write port (address, data, write enable, ready), so software and the keyboard path can paint the frame buffer while VGA scan reads continue.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, pixel/word width (matches VRAM scan data)
DEPTH, 4, request FIFO depth; power of 2, >= 2

Ports:
clk  input  1  system clock (controller-side clock domain)
rst  input  1  asynchronous, active-high reset
req_valid  input  1  single write request valid
req_ready  output  1  request accepted on an edge where req_valid && req_ready
req_addr  input  ADDR_W  target word address
req_data  input  DATA_W  pixel data
fill_start  input  1  one-cycle pulse that starts a block fill
fill_base  input  ADDR_W  first fill address
fill_count  input  ADDR_W  number of words to fill
fill_color  input  DATA_W  fill data
fill_busy  output  1  fill latched or in progress
fill_done  output  1  one-cycle pulse when the fill completes
mem_addr  output  ADDR_W  to SRAM controller addra
mem_din  output  DATA_W  to SRAM controller dina
mem_we  output  1  to SRAM controller wea
mem_ready  input  1  controller MIO_ready; the write completes on an edge with mem_we && mem_ready
busy  output  1  FIFO non-empty, fill_busy, or mem_we high

Behaviour:
- Reset (async, immediate): mem_we=0, mem_addr=0, mem_din=0, fill_busy=0, fill_done=0, busy=0, FIFO emptied, FSM=IDLE. req_ready=1 after reset releases.
- req_ready = !fifo_full && !fill_busy. This is combinational from registered state only, with no dependence on req_valid.
- FSM states:
  - IDLE: mem_we=0.
  - WR: issue FIFO head.
  - FILL: issue fill words.
- IDLE transitions:
  - If FIFO non-empty, go to WR; mem_we=1 with head addr/data from the next edge.
  - Else if a fill is latched, go to FILL.
- Latency: a request accepted at edge N into an empty FIFO in IDLE shows mem_we=1 from edge N+1.
- mem_addr/mem_din/mem_we are registered and must stay stable until an edge with mem_ready=1.
  - On that edge in WR, pop the head.
  - If another entry remains (including one pushed on the same edge), load it and keep mem_we=1 (back-to-back, no bubble).
  - Otherwise go to IDLE with mem_we=0.
- FIFO ordering: writes are issued in strict acceptance order. Simultaneous push and pop are allowed when not full. There is no bypass: a full FIFO blocks pushes even if a pop happens on the same edge.
- fill_start:
  - Sampled only when fill_busy=0; ignored while fill_busy=1.
  - Latches base/count/color and sets fill_busy on that edge. From the next cycle req_ready=0.
  - A request accepted on the same edge as fill_start is written before the fill.
- Fill execution: the fill begins only after the FIFO drains.
  - FILL writes addresses base, base+1, ..., base+count-1, computed mod 2^ADDR_W (wrap to 0 past all-ones).
  - One word completes per mem_ready edge; back-to-back with no bubble.
  - After the last word completes: mem_we=0, fill_busy=0, fill_done=1 for exactly one cycle, then IDLE.
- fill_count=0: no memory writes. fill_done pulses on the edge after the fill would have started (FIFO empty), and fill_busy clears with it.
- mem_ready high while mem_we=0 is ignored.
- Reset asserted mid-write or mid-fill: the current write is abandoned and mem_we drops immediately. Pending FIFO entries and the fill are discarded, with no fill_done.

Test Plan:
- Reset, then one request (addr 0x00100, data 0xF800) with mem_ready tied 1 -> mem_we high exactly 1 cycle, starting 1 cycle after acceptance, carrying 0x00100/0xF800; busy drops the following cycle.
- mem_ready held 0 while pushing 5 requests with DEPTH=4 -> req_ready low after the 4th accept. Releasing mem_ready then gives 4 writes back-to-back in order with stable addr/data during stalls, and the 5th is accepted once a slot frees.
- fill_start base=0x12BFE, count=4, color=0x07E0, mem_ready random -> writes to 0x12BFE..0x12C01 only, req_ready=0 throughout, and a single fill_done pulse.
- Two queued requests, then fill_start -> both requests are written before any fill word; a second fill_start mid-fill is ignored; base=0xFFFFF, count=2 wraps to 0x00000.
- fill_count=0 -> no mem_we; fill_done pulses once, fill_busy clears on the same edge.
- rst asserted mid-fill with mem_we=1 -> mem_we=0 asynchronously, FIFO empty, fill_busy=0, no fill_done; a new request after release is written normally.
